// File: rtl/trans_counter_bank_pkg.sv
// Shared types and defaults for the transition-counter bank and its bench.
package trans_counter_bank_pkg;

   typedef enum logic [1:0] {StIdle, StClear, StRead, StDone} state_e;

   localparam int unsigned DefNumCh = 8;
   localparam int unsigned DefCntW  = 32;

   function automatic int unsigned addr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/trans_cnt_cell.sv
// One channel: edge detect on sig, saturating transition counter and sticky saturation flag.
module trans_cnt_cell #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RESET_L,
   input  logic             sig,
   input  logic             count_en,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   logic prev_q;
   logic toggled;

   assign toggled = sig ^ prev_q;

   // prev follows sig unconditionally so a resumed count never sees a stale edge
   always_ff @(posedge CLK) begin
      if (!RESET_L) begin
         prev_q <= sig;
         cnt    <= '0;
         sat    <= 1'b0;
      end else begin
         prev_q <= sig;
         if (clr) begin
            cnt <= '0;
            sat <= 1'b0;
         end else if (count_en && toggled) begin
            if (&cnt) begin
               sat <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/trans_counter_bank.sv
// Bank of per-channel transition counters with a clear sweep and a valid/ready readout
// that finishes by reporting the total of all counters.
module trans_counter_bank
   import trans_counter_bank_pkg::*;
#(
   parameter  int unsigned NUM_CH = DefNumCh,
   parameter  int unsigned CNT_W  = DefCntW,
   localparam int unsigned ADDR_W = addr_width(NUM_CH),
   localparam int unsigned SUM_W  = CNT_W + ADDR_W
) (
   input  logic              CLK,
   input  logic              RESET_L,
   input  logic [NUM_CH-1:0] sig_in,
   input  logic              cnt_en,
   input  logic              clr_start,
   input  logic              rd_start,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_last,
   output logic              sum_valid,
   output logic [SUM_W-1:0]  sum_out,
   output logic              busy,
   output logic [NUM_CH-1:0] sat_flags
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_CH - 1);

   state_e             state_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [ADDR_W-1:0]  addr_inc;
   logic [SUM_W-1:0]   acc_q;
   logic [SUM_W-1:0]   acc_next;
   logic [CNT_W-1:0]   cnt [NUM_CH];
   logic               count_en;

   assign count_en = (state_q == StIdle) && cnt_en;
   assign addr_inc = addr_q + ADDR_W'(1);
   assign rd_addr  = addr_q;
   assign rd_data  = cnt[addr_q];
   assign acc_next = acc_q + SUM_W'(rd_data);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_cell
      trans_cnt_cell #(
         .CNT_W (CNT_W)
      ) u_cell (
         .CLK      (CLK),
         .RESET_L  (RESET_L),
         .sig      (sig_in[i]),
         .count_en (count_en),
         .clr      ((state_q == StClear) && (addr_q == ADDR_W'(i))),
         .cnt      (cnt[i]),
         .sat      (sat_flags[i])
      );
   end

   always_ff @(posedge CLK) begin
      if (!RESET_L) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         acc_q     <= '0;
         sum_out   <= '0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         sum_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         sum_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (clr_start) begin
                  state_q <= StClear;
                  addr_q  <= '0;
                  busy    <= 1'b1;
               end else if (rd_start) begin
                  state_q  <= StRead;
                  addr_q   <= '0;
                  acc_q    <= '0;
                  busy     <= 1'b1;
                  rd_valid <= 1'b1;
                  rd_last  <= (NUM_CH == 1);
               end
            end
            StClear: begin
               if (addr_q == LastAddr) begin
                  state_q <= StIdle;
                  addr_q  <= '0;
                  busy    <= 1'b0;
               end else begin
                  addr_q <= addr_inc;
               end
            end
            StRead: begin
               if (rd_ready) begin
                  acc_q <= acc_next;
                  if (rd_last) begin
                     // sum_out is loaded here so it is already valid during the DONE pulse
                     state_q   <= StDone;
                     rd_valid  <= 1'b0;
                     rd_last   <= 1'b0;
                     sum_out   <= acc_next;
                     sum_valid <= 1'b1;
                  end else begin
                     addr_q  <= addr_inc;
                     rd_last <= (addr_inc == LastAddr);
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               addr_q  <= '0;
               busy    <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_trans_counter_bank.sv
// Scoreboard bench: expected readout words and sums are queued by the stimulus and popped by a monitor.
module tb_trans_counter_bank;
   import trans_counter_bank_pkg::*;

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] data;
      logic        last;
   } word_t;

   logic        clk = 1'b0;
   logic        RESET_L;
   logic [7:0]  sig_in;
   logic        cnt_en, clr_start, rd_start, rd_ready;
   logic        rd_valid, rd_last, sum_valid, busy;
   logic [2:0]  rd_addr;
   logic [31:0] rd_data;
   logic [34:0] sum_out;
   logic [7:0]  sat_flags;

   logic [7:0]  sig_b;
   logic        cnt_en_b, clr_b, rd_start_b, rd_ready_b;
   logic        rd_valid_b, rd_last_b, sum_valid_b, busy_b;
   logic [2:0]  rd_addr_b;
   logic [3:0]  rd_data_b;
   logic [6:0]  sum_out_b;
   logic [7:0]  sat_b;

   int checks = 0;
   int errors = 0;
   word_t         exp_words[$];
   logic [34:0]   exp_sums[$];
   logic [31:0]   model[8];

   always #5 clk = ~clk;

   trans_counter_bank #(.NUM_CH(DefNumCh), .CNT_W(DefCntW)) u_dut (
      .CLK(clk), .RESET_L(RESET_L), .sig_in(sig_in), .cnt_en(cnt_en), .clr_start(clr_start),
      .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_last(rd_last), .sum_valid(sum_valid), .sum_out(sum_out),
      .busy(busy), .sat_flags(sat_flags)
   );

   trans_counter_bank #(.NUM_CH(8), .CNT_W(4)) u_sat (
      .CLK(clk), .RESET_L(RESET_L), .sig_in(sig_b), .cnt_en(cnt_en_b), .clr_start(clr_b),
      .rd_start(rd_start_b), .rd_ready(rd_ready_b), .rd_valid(rd_valid_b), .rd_addr(rd_addr_b),
      .rd_data(rd_data_b), .rd_last(rd_last_b), .sum_valid(sum_valid_b), .sum_out(sum_out_b),
      .busy(busy_b), .sat_flags(sat_b)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_model();
      logic [34:0] s = '0;
      for (int i = 0; i < 8; i++) begin
         exp_words.push_back('{addr: 3'(i), data: model[i], last: (i == 7)});
         s += 35'(model[i]);
      end
      exp_sums.push_back(s);
   endtask

   task automatic do_read(input bit alt, input bit tgl);
      int n = 0;
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      while (busy && n < 200) begin
         rd_ready = alt ? n[0] : 1'b1;
         if (tgl) sig_in = ~sig_in;
         step();
         n++;
      end
      rd_ready = 1'b0;
      if (n >= 200) chk("read_timeout", 64'(1), 64'(0));
   endtask

   task automatic clear_seq(input bit sel_b);
      int n = 0;
      if (sel_b) clr_b = 1'b1;
      else clr_start = 1'b1;
      step();
      clr_b = 1'b0;
      clr_start = 1'b0;
      while ((sel_b ? busy_b : busy) && n < 50) begin
         n++;
         step();
      end
      chk(sel_b ? "sat_clear_busy_cycles" : "clear_busy_cycles", 64'(n), 64'(8));
   endtask

   // Monitor: pops the scoreboard on every accepted word and every sum pulse
   logic        stall_q = 1'b0;
   logic [2:0]  st_addr;
   logic [31:0] st_data;
   always @(negedge clk) begin
      word_t e;
      if (!RESET_L) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q && rd_valid) begin
            chk("stall_addr", 64'(rd_addr), 64'(st_addr));
            chk("stall_data", 64'(rd_data), 64'(st_data));
         end
         if (rd_valid && rd_ready) begin
            if (exp_words.size() == 0) begin
               chk("unexpected_word", 64'(1), 64'(0));
            end else begin
               e = exp_words.pop_front();
               chk("rd_addr", 64'(rd_addr), 64'(e.addr));
               chk("rd_data", 64'(rd_data), 64'(e.data));
               chk("rd_last", 64'(rd_last), 64'(e.last));
            end
         end
         if (sum_valid) begin
            if (exp_sums.size() == 0) chk("unexpected_sum", 64'(1), 64'(0));
            else chk("sum_out", 64'(sum_out), 64'(exp_sums.pop_front()));
         end
         stall_q = rd_valid && !rd_ready;
         st_addr = rd_addr;
         st_data = rd_data;
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      RESET_L = 1'b0; sig_in = 8'hFF; cnt_en = 1'b0; clr_start = 1'b0;
      rd_start = 1'b0; rd_ready = 1'b0;
      sig_b = 8'h00; cnt_en_b = 1'b0; clr_b = 1'b0; rd_start_b = 1'b0; rd_ready_b = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = '0;
      repeat (3) step();
      RESET_L = 1'b1;
      step();
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_rd_valid", 64'(rd_valid), 64'(0));
      chk("reset_sum_valid", 64'(sum_valid), 64'(0));
      chk("reset_sum_out", 64'(sum_out), 64'(0));
      chk("reset_sat", 64'(sat_flags), 64'(0));

      // ch0 toggled five times
      cnt_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         sig_in[0] = ~sig_in[0];
         step();
      end
      model[0] = 5;
      push_model();
      do_read(1'b0, 1'b0);
      chk("sat_after_five", 64'(sat_flags), 64'(0));

      // saturation on the 4-bit instance
      cnt_en_b = 1'b1;
      for (int k = 0; k < 20; k++) begin
         sig_b[2] = ~sig_b[2];
         step();
      end
      chk("sat_flag_set", 64'(sat_b), 64'(8'h04));
      for (int pass = 0; pass < 2; pass++) begin
         rd_start_b = 1'b1;
         step();
         rd_start_b = 1'b0;
         rd_ready_b = 1'b1;
         for (int i = 0; i < 8; i++) begin
            chk("sat_rd_addr", 64'(rd_addr_b), 64'(i));
            chk("sat_rd_data", 64'(rd_data_b), 64'((i == 2 && pass == 0) ? 15 : 0));
            step();
         end
         rd_ready_b = 1'b0;
         chk("sat_sum_valid", 64'(sum_valid_b), 64'(1));
         chk("sat_sum_out", 64'(sum_out_b), 64'(pass == 0 ? 15 : 0));
         step();
         if (pass == 0) begin
            clear_seq(1'b1);
            chk("sat_flag_cleared", 64'(sat_b), 64'(0));
         end
      end

      // counts 1..8, stalled readout
      clear_seq(1'b0);
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 8; i++) if (i >= k) sig_in[i] = ~sig_in[i];
         step();
      end
      for (int i = 0; i < 8; i++) model[i] = 32'(i + 1);
      push_model();
      do_read(1'b1, 1'b0);

      // simultaneous clear and read: clear wins, no word may appear
      clr_start = 1'b1;
      rd_start = 1'b1;
      step();
      clr_start = 1'b0;
      rd_start = 1'b0;
      rd_ready = 1'b1;
      begin
         int n = 0;
         while (busy && n < 50) begin
            chk("rd_valid_in_clear", 64'(rd_valid), 64'(0));
            n++;
            step();
         end
         chk("clr_rd_busy_cycles", 64'(n), 64'(8));
      end
      rd_ready = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = '0;
      push_model();
      do_read(1'b0, 1'b0);

      // edges during READ and with cnt_en=0 are discarded
      sig_in[3] = ~sig_in[3];
      step();
      sig_in[3] = ~sig_in[3];
      step();
      model[3] = 2;
      push_model();
      do_read(1'b0, 1'b1);
      cnt_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sig_in = ~sig_in;
         step();
      end
      cnt_en = 1'b1;
      step();
      step();
      sig_in[3] = ~sig_in[3];
      step();
      model[3] = 3;
      push_model();
      do_read(1'b0, 1'b0);

      // reset while word 3 is presented
      for (int i = 0; i < 3; i++) exp_words.push_back('{addr: 3'(i), data: model[i], last: 1'b0});
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      rd_ready = 1'b1;
      repeat (3) step();
      chk("pre_reset_addr", 64'(rd_addr), 64'(3));
      RESET_L = 1'b0;
      rd_ready = 1'b0;
      step();
      RESET_L = 1'b1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_rd_valid", 64'(rd_valid), 64'(0));
      chk("abort_sum_valid", 64'(sum_valid), 64'(0));
      for (int i = 0; i < 8; i++) model[i] = '0;
      push_model();
      do_read(1'b0, 1'b0);

      repeat (3) step();
      chk("words_left", 64'(exp_words.size()), 64'(0));
      chk("sums_left", 64'(exp_sums.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/trans_counter_bank.md
Name: trans_counter_bank

Overview:
- Synthesizable, clocked successor to the transition-counter memory and instrumentation pair.
- Counts 0->1 and 1->0 transitions on NUM_CH monitored signals, one saturating counter per channel.
- A sequencer clears the counters by sweeping the addresses, one per cycle.
- A valid/ready readout streams every counter in address order and then reports the total transition count.
- Sits beside the gate-level netlist under test; feeds the power-estimation bench.

Parameters:
NUM_CH, 8, number of monitored signals / counters (>=1)
CNT_W, 32, width of each transition counter
ADDR_W (localparam), max(1,$clog2(NUM_CH)), counter address width
SUM_W (localparam), CNT_W+ADDR_W, width of total sum (cannot overflow)

Ports:
CLK  input  1  single clock; all state updates on rising edge
RESET_L  input  1  synchronous, active-low reset
sig_in  input  NUM_CH  monitored signals, already synchronous to CLK
cnt_en  input  1  counting enable
clr_start  input  1  request clear sweep (sampled in IDLE only)
rd_start  input  1  request readout (sampled in IDLE only)
rd_ready  input  1  consumer accepts current readout word
rd_valid  output  1  readout word valid
rd_addr  output  ADDR_W  address of current readout word
rd_data  output  CNT_W  counter value at rd_addr
rd_last  output  1  current word is address NUM_CH-1
sum_valid  output  1  one-cycle pulse: sum_out updated
sum_out  output  SUM_W  total of all counters from last readout; holds value
busy  output  1  FSM not in IDLE
sat_flags  output  NUM_CH  sticky per-channel saturation flags

Behaviour:
- Reset (RESET_L=0 at a CLK edge):
  - All counters, sat_flags, sum_out and the address register go to 0.
  - FSM goes to IDLE; rd_valid, rd_last, sum_valid and busy go to 0.
  - prev register loads sig_in, so no spurious edge is counted on exit.
  - Reset in any state, including mid-CLEAR or mid-READ, aborts the operation immediately.
- Edge detect:
  - edge = sig_in ^ prev.
  - prev <= sig_in every cycle in every state, so resuming counting never counts a stale edge.
- Counting:
  - Only in IDLE with cnt_en=1: cnt[i] increments by 1 when edge[i] is set.
  - 1-cycle latency: an edge sampled at cycle n is visible in cnt at n+1.
  - Edges arriving in CLEAR, READ or DONE, or with cnt_en=0, are discarded. The snapshot stays frozen.
- Saturation: if cnt[i] is all-ones and edge[i]=1, cnt[i] holds and sat_flags[i] <= 1. The flag stays set until reset or a clear.
- FSM states are IDLE, CLEAR, READ and DONE.
- IDLE:
  - clr_start=1 -> CLEAR with addr=0. Clear has priority if clr_start and rd_start are high together.
  - Otherwise rd_start=1 -> READ with addr=0.
- CLEAR:
  - Each cycle: cnt[addr] <= 0, sat_flags[addr] <= 0, addr++.
  - After addr=NUM_CH-1 -> IDLE.
  - Total duration is exactly NUM_CH cycles, with busy=1 throughout.
- READ:
  - rd_valid=1, rd_addr=addr, rd_data=cnt[addr], rd_last=(addr==NUM_CH-1).
  - The accumulator is cleared on entry.
  - On rd_valid&&rd_ready: acc += zero-extended rd_data.
  - On that transfer, if not last: addr++. If last: -> DONE.
  - With rd_ready=0, rd_addr and rd_data hold stable; no timeout.
- DONE (one cycle): sum_out <= final acc, sum_valid=1, rd_valid=0, then -> IDLE.
- Starts are ignored while busy; they are not queued.
- NUM_CH=1: a single-word readout with rd_last=1 on the first word.

Decomposition:
- Shared package/header: FSM state encoding constants (IDLE, CLEAR, READ, DONE) and the default NUM_CH/CNT_W defines reused by the bench.
- One natural sub-module: trans_cnt_cell, holding one channel's counter, edge detect and saturation logic. Ports: CLK, RESET_L, sig, count_en, clr, cnt, sat.
- The top generates NUM_CH instances plus the FSM and read mux.

Test Plan:
- Reset with sig_in=8'hFF, then cnt_en=1 and ch0 toggled 5 times -> readout gives word0=5, all others 0, sum_out=5, sat_flags=0.
- CNT_W=4, ch2 toggled 20 times -> cnt[2]=15, sat_flags[2]=1; clear sweep -> cnt[2]=0, sat_flags[2]=0, busy high exactly 8 cycles.
- Counts {1,2,...,8}, readout with rd_ready alternating 0/1:
  - rd_data and rd_addr stable while stalled, and words 1..8 appear in address order.
  - rd_last high only on addr 7.
  - sum_valid pulses once with sum_out=36.
- clr_start and rd_start high on the same cycle with nonzero counts -> CLEAR runs, rd_valid never asserts, a subsequent readout gives all zeros.
- Toggle all channels during READ and while cnt_en=0 -> no counter changes; first edge after returning to IDLE with cnt_en=1 counts exactly 1.
- RESET_L=0 for one cycle at readout word 3 -> next cycle busy=0, rd_valid=0, sum_valid=0, all counters read back 0.
